flow_key_hasher: RTL and testbench
==================================

Name: flow_key_hasher

Overview:
- Upstream feeder stage for flow_table.
- Collects the flow-key words that software writes to the flow-key register (0x8000A00C); the AXI register block forwards each write as a one-cycle strobe.
- Assembles KEY_WORDS words into a complete key, computing a rotate-XOR hash incrementally as the words arrive.
- Presents {key, hash index} to flow_table over a valid/ready handshake.

Parameters:
KEY_WORDS, 5, number of 32-bit words per flow key; key width KW = 32*KEY_WORDS
HASH_W, 10, width of hash index into flow_table (1..16)
ROT, 5, left-rotate amount per hash step (1..31)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  one-cycle strobe: register write to flow-key address
wr_data  in  32  write data accompanying wr_en
clear  in  1  one-cycle strobe: abort partial key, clear drop_err
out_valid  out  1  key and hash available to flow_table
out_ready  in  1  flow_table accepts key
out_key  out  KW  assembled key; first written word in [KW-1:KW-32]
out_hash  out  HASH_W  hash index
word_cnt  out  3  words collected for the current key (0..KEY_WORDS-1 while collecting)
drop_err  out  1  sticky: a write arrived while the output was held

Behaviour:
- Reset: rst_n sampled on the rising edge of clk.
  - Outputs: out_valid=0, out_key=0, out_hash=0, word_cnt=0, drop_err=0.
  - Internal state: hash accumulator h=0, state=COLLECT.
  - Reset mid-key discards all collected words.
- States: COLLECT and HOLD.
- COLLECT, on wr_en:
  - Shift wr_data into the key register: key <= {key[KW-33:0], wr_data}. After KEY_WORDS writes, word 0 sits in the MSBs.
  - Hash step: h <= rotl32(h, ROT) ^ wr_data.
  - word_cnt increments by 1.
- Key complete: the write that brings the count to KEY_WORDS does the following:
  - Transitions to HOLD.
  - Asserts out_valid on the next cycle (1-cycle latency from the last write).
  - Resets word_cnt to 0.
  - Registers out_hash = (h_final ^ (h_final >> 16))[HASH_W-1:0], where h_final includes the last word.
- HOLD:
  - out_valid=1; out_key and out_hash stay stable until the handshake.
  - On out_valid & out_ready: out_valid <= 0, h <= 0, state <= COLLECT.
  - A write in the handshake cycle itself is dropped, because the state is still HOLD.
- Write in HOLD: wr_data is dropped and drop_err is set (sticky). Key and hash stay unchanged.
- clear:
  - In COLLECT: h <= 0, word_cnt <= 0, key <= 0, drop_err <= 0.
  - In HOLD: clears drop_err only; the pending output is unaffected.
  - clear and wr_en in the same cycle in COLLECT: clear wins and the word is discarded.
- out_ready while out_valid=0: ignored.
- Back-to-back keys: a new key can begin the cycle after the handshake. Sustained throughput is one key per KEY_WORDS+1 cycles when out_ready is held high.
- All outputs registered. No combinational path from inputs to outputs.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> all outputs 0, word_cnt=0.
- 5 writes of 0xFFFFFFFF, out_ready=1 -> out_valid 1 cycle after 5th write; out_key = all ones (160 bits); h_final=0xFFFFFFFF; out_hash=0x000; handshake completes; out_valid=0 next cycle.
- Writes 0x00000001, 0, 0, 0, 0 -> h_final=0x00100000; out_hash=0x010; out_key = 0x00000001 followed by 128 zero bits.
- Complete a key with out_ready=0 held 10 cycles, then 2 extra writes -> out_valid stays 1, out_key/out_hash unchanged, drop_err=1. Raise out_ready -> handshake completes. Then clear -> drop_err=0.
- 3 writes, then clear (also clear together with wr_en in the same cycle) -> word_cnt=0, no out_valid. 5 subsequent writes produce the same hash as a fresh key.
- 3 writes, then rst_n=0 for 1 cycle, then 5 writes of 0xFFFFFFFF -> out_hash=0x000, partial key discarded. Two back-to-back keys with out_ready=1 -> each out_valid pulse 1 cycle, no loss.

Source files
------------

// File: rtl/flow_key_hasher_if.sv
// Write-side and flow_table-side signals of the flow-key hasher.
interface flow_key_hasher_if #(
    parameter int unsigned KEY_WORDS = 5,
    parameter int unsigned HASH_W    = 10
);
    localparam int unsigned KW = 32 * KEY_WORDS;

    logic              wr_en;
    logic [31:0]       wr_data;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [KW-1:0]     out_key;
    logic [HASH_W-1:0] out_hash;
    logic [2:0]        word_cnt;
    logic              drop_err;

    // Environment side: register block and flow_table
    modport master (
        output wr_en, wr_data, clear, out_ready,
        input  out_valid, out_key, out_hash, word_cnt, drop_err
    );

    // Hasher side
    modport slave (
        input  wr_en, wr_data, clear, out_ready,
        output out_valid, out_key, out_hash, word_cnt, drop_err
    );
endinterface

// File: rtl/flow_key_hasher.sv
// Assembles flow-key words from register writes, hashes them on the fly
// with a rotate-XOR, and offers {key, hash index} to flow_table.
module flow_key_hasher #(
    parameter int unsigned KEY_WORDS = 5,
    parameter int unsigned HASH_W    = 10,
    parameter int unsigned ROT       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    flow_key_hasher_if.slave bus
);
    localparam int unsigned KW    = 32 * KEY_WORDS;
    localparam int unsigned ROT_R = 32 - ROT;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q;
    logic [31:0]       h_q;
    logic [KW-1:0]     key_q;
    logic [HASH_W-1:0] hash_q;
    logic [2:0]        word_cnt_q;
    logic              valid_q;
    logic              drop_err_q;

    logic [31:0]       h_step_d;
    logic              last_word_d;

    // Next hash value if the current write is accepted
    always_comb begin
        h_step_d    = ((h_q << ROT) | (h_q >> ROT_R)) ^ bus.wr_data;
        last_word_d = (word_cnt_q == 3'(KEY_WORDS - 1));
    end

    // Collect/hold state machine with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            h_q        <= '0;
            key_q      <= '0;
            hash_q     <= '0;
            word_cnt_q <= '0;
            valid_q    <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    // clear has priority: a word written alongside it is discarded
                    if (bus.clear) begin
                        h_q        <= '0;
                        key_q      <= '0;
                        word_cnt_q <= '0;
                        drop_err_q <= 1'b0;
                    end else if (bus.wr_en) begin
                        key_q <= KW'({key_q, bus.wr_data});
                        h_q   <= h_step_d;
                        if (last_word_d) begin
                            word_cnt_q <= '0;
                            hash_q     <= HASH_W'(h_step_d ^ (h_step_d >> 16));
                            valid_q    <= 1'b1;
                            state_q    <= HOLD;
                        end else begin
                            word_cnt_q <= word_cnt_q + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    // Writes cannot be absorbed while the key is pending
                    if (bus.wr_en) begin
                        drop_err_q <= 1'b1;
                    end
                    if (bus.clear) begin
                        drop_err_q <= 1'b0;
                    end
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        h_q     <= '0;
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_key   = key_q;
    assign bus.out_hash  = hash_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_flow_key_hasher.sv
// Scoreboard bench for flow_key_hasher: stimulus pushes expected {key, hash},
// a monitor pops and compares on every output handshake.
module tb_flow_key_hasher;
    localparam int unsigned KEY_WORDS = 5;
    localparam int unsigned HASH_W    = 10;
    localparam int unsigned KW        = 32 * KEY_WORDS;

    typedef struct packed {
        logic [KW-1:0]     key;
        logic [HASH_W-1:0] hash;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];

    flow_key_hasher_if #(.KEY_WORDS(KEY_WORDS), .HASH_W(HASH_W)) bif ();

    flow_key_hasher #(.KEY_WORDS(KEY_WORDS), .HASH_W(HASH_W), .ROT(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] d, input logic clr);
        bif.wr_en   = we;
        bif.wr_data = d;
        bif.clear   = clr;
        tick();
        bif.wr_en   = 1'b0;
        bif.wr_data = '0;
        bif.clear   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        drive(1'b1, d, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare each accepted output against the scoreboard head
    initial begin : monitor
        exp_t e;
        logic prev_hs;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("valid_pulse", 160'(bif.out_valid), 160'(0));
                end
                prev_hs = 1'b0;
                if (bif.out_valid && bif.out_ready) begin
                    prev_hs = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got key %h expected none", bif.out_key);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_key", 160'(bif.out_key), 160'(e.key));
                        chk("out_hash", 160'(bif.out_hash), 160'(e.hash));
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [KW-1:0] k_ones;
        logic [KW-1:0] k_one;
        logic [KW-1:0] k_three;
        logic [KW-1:0] k_pair;
        k_ones  = {KW{1'b1}};
        k_one   = {32'h0000_0001, 128'h0};
        k_three = 160'h3_0000;
        k_pair  = {96'h0, 32'h0000_0001, 32'h0000_0002};
        n_cmp = 0;
        n_bad = 0;
        bif.wr_en     = 1'b0;
        bif.wr_data   = '0;
        bif.clear     = 1'b0;
        bif.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset for 3 cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", 160'(bif.out_valid), 160'(0));
        chk("rst_key", 160'(bif.out_key), 160'(0));
        chk("rst_hash", 160'(bif.out_hash), 160'(0));
        chk("rst_cnt", 160'(bif.word_cnt), 160'(0));
        chk("rst_drop", 160'(bif.drop_err), 160'(0));

        // All-ones key: h_final = 0xFFFFFFFF, hash 0x000
        exp_q.push_back('{key: k_ones, hash: 10'h000});
        for (int i = 0; i < 4; i++) wr(32'hFFFF_FFFF);
        chk("cnt_4", 160'(bif.word_cnt), 160'(4));
        chk("valid_before_last", 160'(bif.out_valid), 160'(0));
        wr(32'hFFFF_FFFF);
        chk("valid_latency", 160'(bif.out_valid), 160'(1));
        chk("cnt_wrap", 160'(bif.word_cnt), 160'(0));
        drain();
        tick();

        // Single set bit in word 0: h_final = 0x00100000, hash 0x010
        exp_q.push_back('{key: k_one, hash: 10'h010});
        wr(32'h1);
        for (int i = 0; i < 4; i++) wr(32'h0);
        drain();
        tick();

        // Held output with dropped writes
        bif.out_ready = 1'b0;
        exp_q.push_back('{key: k_three, hash: 10'h003});
        for (int i = 0; i < 4; i++) wr(32'h0);
        wr(32'h0003_0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 160'(bif.out_valid), 160'(1));
        end
        wr(32'hDEAD_BEEF);
        wr(32'h1234_5678);
        chk("drop_err_set", 160'(bif.drop_err), 160'(1));
        chk("hold_key", 160'(bif.out_key), 160'(k_three));
        chk("hold_hash", 160'(bif.out_hash), 160'(10'h003));
        bif.out_ready = 1'b1;
        drain();
        tick();
        chk("drop_err_sticky", 160'(bif.drop_err), 160'(1));
        drive(1'b0, 32'h0, 1'b1);
        chk("drop_err_clear", 160'(bif.drop_err), 160'(0));

        // Partial key aborted by clear
        for (int i = 0; i < 3; i++) wr(32'hFFFF_FFFF);
        chk("cnt_3", 160'(bif.word_cnt), 160'(3));
        drive(1'b0, 32'h0, 1'b1);
        chk("clear_cnt", 160'(bif.word_cnt), 160'(0));
        chk("clear_valid", 160'(bif.out_valid), 160'(0));
        // clear together with a write discards the word
        wr(32'hAAAA_AAAA);
        wr(32'h5555_5555);
        drive(1'b1, 32'h7777_7777, 1'b1);
        chk("clear_wr_cnt", 160'(bif.word_cnt), 160'(0));
        chk("clear_wr_valid", 160'(bif.out_valid), 160'(0));
        exp_q.push_back('{key: k_one, hash: 10'h010});
        wr(32'h1);
        for (int i = 0; i < 4; i++) wr(32'h0);
        drain();
        tick();

        // Reset in the middle of a key
        for (int i = 0; i < 3; i++) wr(32'h0000_0001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_cnt", 160'(bif.word_cnt), 160'(0));
        exp_q.push_back('{key: k_ones, hash: 10'h000});
        for (int i = 0; i < 5; i++) wr(32'hFFFF_FFFF);
        drain();
        tick();

        // Back-to-back keys at full rate
        exp_q.push_back('{key: k_ones, hash: 10'h000});
        exp_q.push_back('{key: k_pair, hash: 10'h022});
        for (int i = 0; i < 5; i++) wr(32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 3; i++) wr(32'h0);
        wr(32'h1);
        wr(32'h2);
        chk("b2b_valid", 160'(bif.out_valid), 160'(1));
        drain();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
